// File: rtl/lm07_read_ctrl_if.sv
// lm07_read_ctrl_if: host request/response bundle for the LM07 read controller
interface lm07_read_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       valid;
    logic [9:0] temp;
    modport master (output start, input busy, done, valid, temp);
    modport slave  (input start, output busy, done, valid, temp);
endinterface

// File: rtl/lm07_read_ctrl.sv
// lm07_read_ctrl: sequences one LM07 read (cs window, load strobe, 10-bit MSB-first shift)
module lm07_read_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    lm07_read_ctrl_if.slave host,
    input  logic            sio,
    output logic            cs,
    output logic            sclk,
    output logic            sensor_rst
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int PW = $clog2(POLL_CYCLES + 1) + 1;
    localparam logic [CW-1:0] H_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_END  = CW'(CLK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, DATA, END} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic          half;
    logic [9:0]    shift;
    logic [PW-1:0] poll_cnt;
    logic          poll_exp;
    assign poll_exp = (POLL_CYCLES > 0) && (poll_cnt == P_LAST);
    // END runs one cycle past H so done lands on the edge after the END window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            half       <= 1'b0;
            shift      <= '0;
            poll_cnt   <= '0;
            cs         <= 1'b1;
            sclk       <= 1'b0;
            sensor_rst <= 1'b1;
            host.busy  <= 1'b0;
            host.done  <= 1'b0;
            host.temp  <= '0;
            host.valid <= 1'b0;
        end else begin
            host.done <= 1'b0;
            case (state)
                IDLE:
                    if (host.start || poll_exp) begin
                        state      <= SETUP;
                        cnt        <= '0;
                        poll_cnt   <= '0;
                        cs         <= 1'b0;
                        sensor_rst <= 1'b0;
                        host.busy  <= 1'b1;
                    end else if (POLL_CYCLES > 0) begin
                        poll_cnt <= poll_cnt + PW'(1);
                    end
                SETUP:
                    if (cnt == H_LAST) begin
                        state <= LOAD;
                        cnt   <= '0;
                        sclk  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                LOAD:
                    if (cnt == H_LAST) begin
                        state      <= DATA;
                        cnt        <= '0;
                        sclk       <= 1'b0;
                        sensor_rst <= 1'b1;
                        half       <= 1'b0;
                        bit_cnt    <= 4'd9;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                DATA:
                    if (cnt != H_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        if (!half) begin
                            shift <= {shift[8:0], sio};
                            sclk  <= 1'b1;
                            half  <= 1'b1;
                        end else if (bit_cnt == 4'd0) begin
                            state <= END;
                            sclk  <= 1'b0;
                            cs    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            sclk    <= 1'b0;
                            half    <= 1'b0;
                        end
                    end
                END:
                    if (cnt == H_END) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        host.temp  <= shift;
                        host.done  <= 1'b1;
                        host.valid <= 1'b1;
                        host.busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lm07_read_ctrl.sv
// tb_lm07_read_ctrl: scoreboard bench driving three configurations against LM07 sensor models
module tb_lm07_read_ctrl;
    typedef struct { logic [9:0] val; int cyc; } exp_t;
    localparam int HA = 4;
    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a, rst_b, rst_c;
    logic cs_a, cs_b, cs_c, sclk_a, sclk_b, sclk_c, srst_a, srst_b, srst_c, sio_a, sio_b, sio_c;
    logic [9:0] sens_a, sens_b, sens_c;
    logic [9:0] sh_a = '0, sh_b = '0, sh_c = '0;
    lm07_read_ctrl_if ha(), hb(), hc();

    lm07_read_ctrl #(.CLK_DIV(HA), .POLL_CYCLES(0)) dut_a (
        .clk(clk), .reset(rst_a), .host(ha), .sio(sio_a), .cs(cs_a), .sclk(sclk_a), .sensor_rst(srst_a));
    lm07_read_ctrl #(.CLK_DIV(1), .POLL_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst_b), .host(hb), .sio(sio_b), .cs(cs_b), .sclk(sclk_b), .sensor_rst(srst_b));
    lm07_read_ctrl #(.CLK_DIV(2), .POLL_CYCLES(50)) dut_c (
        .clk(clk), .reset(rst_c), .host(hc), .sio(sio_c), .cs(cs_c), .sclk(sclk_c), .sensor_rst(srst_c));

    // Sensor: loads on an sclk rise while its reset is low, otherwise shifts the next bit out
    always @(posedge sclk_a) if (!cs_a) sh_a <= !srst_a ? sens_a : {sh_a[8:0], 1'b0};
    always @(posedge sclk_b) if (!cs_b) sh_b <= !srst_b ? sens_b : {sh_b[8:0], 1'b0};
    always @(posedge sclk_c) if (!cs_c) sh_c <= !srst_c ? sens_c : {sh_c[8:0], 1'b0};
    assign sio_a = sh_a[9];
    assign sio_b = sh_b[9];
    assign sio_c = sh_c[9];

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    exp_t qa[$], qb[$], qc[$];
    int   qc_acc[$];
    int   last_done_b = -1;
    logic pcs_b = 1'b1, pcs_c = 1'b1, psclk_a = 1'b0;
    int   n_cs_low = 0, n_srst_low = 0, n_srst_cs = 0, n_rise = 0, n_rise_srst = 0, n_glitch = 0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ha.done) begin
            if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_temp", ha.temp, e.val);
                chk("a_done_cycle", cyc, e.cyc);
                chk("a_valid", ha.valid, 1);
                chk("a_busy_in_done", ha.busy, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (pcs_b && !cs_b && last_done_b >= 0) chk("b_cs_fall_after_done", cyc, last_done_b + 1);
        pcs_b <= cs_b;
        if (hb.done) begin
            last_done_b <= cyc;
            if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_temp", hb.temp, e.val);
                chk("b_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (pcs_c && !cs_c) begin
            if (qc_acc.size() == 0) chk("c_unexpected_read", 1, 0);
            else chk("c_cs_fall_cycle", cyc, qc_acc.pop_front());
        end
        pcs_c <= cs_c;
        if (hc.done) begin
            if (qc.size() == 0) chk("c_unexpected_done", 1, 0);
            else begin
                e = qc.pop_front();
                chk("c_temp", hc.temp, e.val);
                chk("c_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : track
        if (!cs_a) n_cs_low <= n_cs_low + 1;
        if (!srst_a) n_srst_low <= n_srst_low + 1;
        if (!srst_a && !cs_a) n_srst_cs <= n_srst_cs + 1;
        if (sclk_a && !psclk_a) begin
            n_rise <= n_rise + 1;
            if (!srst_a) n_rise_srst <= n_rise_srst + 1;
        end
        psclk_a <= sclk_a;
        if ((sclk_a && cs_a) || (sclk_b && cs_b) || (sclk_c && cs_c)) n_glitch <= n_glitch + 1;
    end

    task automatic read_a(input logic [9:0] v, input bit extra);
        exp_t e;
        int t;
        sens_a = v;
        e.val = v;
        e.cyc = cyc + 23 * HA + 2;
        qa.push_back(e);
        ha.start = 1'b1;
        @(negedge clk);
        ha.start = 1'b0;
        if (extra) begin
            repeat ($urandom_range(2, 20)) @(negedge clk);
            ha.start = 1'b1;
            repeat ($urandom_range(1, 10)) @(negedge clk);
            ha.start = 1'b0;
        end
        t = 0;
        while (!ha.done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ha.done) chk("a_done_timeout", 0, 1);
    endtask

    initial begin
        int a0, r, t, b_cs, b_sr, b_sc, b_ri, b_rs;
        exp_t e;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ha.start = 1'b0; hb.start = 1'b0; hc.start = 1'b0;
        sens_a = 10'h35B; sens_b = 10'($urandom_range(0, 1023)); sens_c = 10'h35B;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_sensor_rst", srst_a, 1);
        chk("rst_busy", ha.busy, 0);
        chk("rst_done", ha.done, 0);
        chk("rst_temp", ha.temp, 0);
        chk("rst_valid", ha.valid, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        ha.start = 1'b1;
        @(negedge clk);
        ha.start = 1'b0;
        repeat (39) @(negedge clk);
        chk("mid_busy", ha.busy, 1);
        chk("mid_cs", cs_a, 0);
        #2 rst_a = 1'b0;
        #1;
        chk("abort_cs", cs_a, 1);
        chk("abort_sclk", sclk_a, 0);
        chk("abort_sensor_rst", srst_a, 1);
        chk("abort_busy", ha.busy, 0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_temp", ha.temp, 0);
        chk("abort_valid", ha.valid, 0);
        b_cs = n_cs_low; b_sr = n_srst_low; b_sc = n_srst_cs; b_ri = n_rise; b_rs = n_rise_srst;
        read_a(10'h35B, 1'b0);
        chk("basic_cs_low_cycles", n_cs_low - b_cs, 22 * HA);
        chk("basic_srst_low_cycles", n_srst_low - b_sr, 2 * HA);
        chk("basic_srst_in_cs_window", n_srst_cs - b_sc, 2 * HA);
        chk("basic_sclk_rises", n_rise - b_ri, 11);
        chk("basic_rises_in_load", n_rise_srst - b_rs, 1);
        read_a(10'h200, 1'b1);
        read_a(10'h001, 1'b1);
        read_a(10'h3FF, 1'b1);
        read_a(10'h000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            read_a(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end
        // back-to-back reads with start held high: one accept every 25 cycles at H=1
        @(negedge clk);
        a0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            e.val = sens_b;
            e.cyc = a0 + 25 * k + 24;
            qb.push_back(e);
        end
        hb.start = 1'b1;
        while (cyc < a0 + 99) @(negedge clk);
        hb.start = 1'b0;
        repeat (40) @(negedge clk);
        // auto-poll: first read 50 cycles after release, then 50 after each done
        @(negedge clk);
        r = cyc;
        rst_c = 1'b1;
        t = r + 50;
        for (int k = 0; k < 3; k++) begin
            qc_acc.push_back(t);
            e.val = 10'h35B;
            e.cyc = t + 23 * 2 + 1;
            qc.push_back(e);
            t = e.cyc + 50;
        end
        while (cyc < t - 40) @(negedge clk);
        rst_c = 1'b0;
        repeat (5) @(negedge clk);
        chk("a_reads_outstanding", qa.size(), 0);
        chk("b_reads_outstanding", qb.size(), 0);
        chk("c_reads_outstanding", qc.size(), 0);
        chk("c_accepts_outstanding", qc_acc.size(), 0);
        chk("sclk_outside_cs", n_glitch, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lm07_read_ctrl.md
# lm07_read_ctrl

Host-side controller that sequences one read of the LM07 serial temperature sensor. On request it runs the chip-select window, issues the sensor load pulse, and clocks out the 10 data bits MSB first. It assembles the reading and presents it to the requester with a one-cycle done pulse. An optional periodic poll mode issues reads with no host request. The block sits between the system-clock logic and the sensor's cs/sclk/sio/reset pins.

## Interface
- CLK_DIV, 4: clk cycles per sclk half-period; legal range ≥ 1.
- POLL_CYCLES, 0: 0 disables auto-poll; N > 0 starts a read N clk cycles after the previous done pulse, and the first read N cycles after reset release.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- start  input  1  read request; sampled only in IDLE.
- sio  input  1  sensor serial data, MSB first.
- cs  output  1  sensor chip select, active-low.
- sclk  output  1  sensor serial clock.
- sensor_rst  output  1  sensor load strobe, active-low; the sensor loads its value on an sclk rising edge while this is low.
- busy  output  1  high from the cycle after the request is accepted until done.
- done  output  1  one-cycle pulse when temp is updated.
- temp  output  10  last complete reading.
- valid  output  1  sticky; set at the first done, cleared only by reset.

## Operation
- All outputs are registered.
- Reset values: cs=1, sclk=0, sensor_rst=1, busy=0, done=0, temp=0, valid=0, state IDLE, counters 0.
- States and transitions:
  - IDLE → SETUP on start=1, or on poll counter expiry when POLL_CYCLES>0.
  - SETUP (H cycles): cs=0, sclk=0, sensor_rst=0.
  - LOAD (H cycles): sclk=1, sensor_rst=0.
  - DATA (10 bit periods, 2H cycles each): low half then high half. sensor_rst=1 from the first DATA cycle. In the last cycle of each low half, sio is shifted into the LSB of the shift register, so bit 9 is captured first.
  - END (H cycles): cs=1, sclk=0.
  - END → IDLE. In the transition cycle, temp ← shift register, done=1, valid=1, busy=0.
- H = CLK_DIV.
- cs changes only while sclk=0, so the sensor's gated clock (~cs & sclk) never glitches.
- sensor_rst is low for exactly one sclk rising edge (the LOAD edge) per transaction.
- A start during busy is ignored and not queued. If start and poll expiry occur in the same cycle, one read is performed.
- The poll counter runs only in IDLE. It is reset by done and holds at its terminal value until the read is accepted.
- A reset asserted mid-transaction aborts it. Outputs return to reset values asynchronously, and temp/valid are not updated.
- The bit counter runs 9 down to 0. Sampling ends after bit 0; the 10th rising edge is still issued.

## Timing
- Request accepted in the cycle start=1 is seen in IDLE. cs falls on the next clk edge.
- The transaction lasts 23·H clk cycles: SETUP H + LOAD H + DATA 20H + END H.
- done is asserted in the cycle after END completes, i.e. the rising edge 23·H+1 after the accepting edge.
- The earliest next acceptance is the cycle after done. busy is low in the done cycle.
- sio is sampled H−1 cycles after sclk falls, which is the last low cycle before the rising edge.
- The sensor shifts on the following rising edge, so sio has a full low half-period to settle.
- sclk period is 2H clk cycles with 50% duty. sclk toggles only inside the cs=0 window.

## Test plan
- Basic read: sensor model preloaded with 10'h35B, CLK_DIV=4, one start pulse → cs low for 88 cycles and exactly 11 sclk rising edges. done pulses 93 cycles after acceptance (23·H+1 = 93), with temp=10'h35B and valid=1.
- Load strobe: probe sensor_rst in the basic read → low exactly from SETUP start through LOAD. Exactly one sclk rising edge occurs while sensor_rst=0.
- Busy/start: start held high continuously with CLK_DIV=1 → back-to-back reads, each done 24 cycles after acceptance. The next cs fall occurs one cycle after each done. Extra start pulses during busy produce no extra reads.
- Mid-read reset: assert reset 40 cycles into a read (CLK_DIV=4) → same cycle cs=1, sclk=0, sensor_rst=1, busy=0. temp and valid stay at reset values. A read after release returns 10'h35B.
- Auto-poll: POLL_CYCLES=50, CLK_DIV=2, no start → first cs fall 50 cycles after reset release. Subsequent reads start 50 cycles after each done, and every done carries 10'h35B.
- Bit order: sensor value 10'h200, then 10'h001 → temp reads back 10'h200 and 10'h001 respectively, with no bit reversal or shift error.
